// File: rtl/mpu_store.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : mpu_store                                                     |
// | Purpose  : Matrix store unit. Accepts a store request, fetches the       |
// |            matrix dimensions from the MPU register file, validates them  |
// |            and then streams every element out on a valid/ready stream.   |
// |            A two-entry output buffer plus at most one outstanding        |
// |            register-file read sustains one element per cycle.            |
// | Option   : STORE_TRANSPOSE_EN - when defined, adds mem_store_transpose_in|
// |            which selects column-major traversal and swaps the reported   |
// |            sizes. When undefined the port is absent and traversal is     |
// |            always row-major.                                             |
// | Ports    :                                                               |
// |   clk, rst                  clock, synchronous active-low reset          |
// |   store_en_in               store request strobe                         |
// |   mem_store_addr_in         source matrix address                        |
// |   mem_store_transpose_in    column-major request (option only)           |
// |   mem_store_ack_out         one-cycle pulse, request accepted            |
// |   mem_store_error_out       dimension error, held until next request     |
// |   mem_store_valid_out       output element valid                         |
// |   mem_store_ready_in        sink ready                                   |
// |   mem_store_element_out     element data                                 |
// |   mem_store_last_out        final element of the matrix                  |
// |   mem_m/n_store_size_out    rows / columns being stored                  |
// |   reg_store_en_out          size-read request to register file           |
// |   reg_store_addr_out        matrix address to register file              |
// |   reg_m/n_store_size_in     stored sizes, valid cycle after request      |
// |   reg_store_rd_out          element read strobe                          |
// |   reg_i/j_store_loc_out     element read row / column                    |
// |   reg_store_element_in      read data, valid cycle after read strobe     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mpu_store #(
   parameter int FP              = 32,
   parameter int M               = 4,
   parameter int N               = 4,
   parameter int MBITS           = 2,
   parameter int NBITS           = 2,
   parameter int MATRIX_REG_SIZE = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       store_en_in,
   input  logic [MATRIX_REG_SIZE-1:0] mem_store_addr_in,
`ifdef STORE_TRANSPOSE_EN
   input  logic                       mem_store_transpose_in,
`endif
   output logic                       mem_store_ack_out,
   output logic                       mem_store_error_out,
   output logic                       mem_store_valid_out,
   input  logic                       mem_store_ready_in,
   output logic [FP-1:0]              mem_store_element_out,
   output logic                       mem_store_last_out,
   output logic [MBITS:0]             mem_m_store_size_out,
   output logic [NBITS:0]             mem_n_store_size_out,
   output logic                       reg_store_en_out,
   output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
   input  logic [MBITS:0]             reg_m_store_size_in,
   input  logic [NBITS:0]             reg_n_store_size_in,
   output logic                       reg_store_rd_out,
   output logic [MBITS:0]             reg_i_store_loc_out,
   output logic [NBITS:0]             reg_j_store_loc_out,
   input  logic [FP-1:0]              reg_store_element_in
);

   localparam logic [1:0] STORE_IDLE   = 2'd0;
   localparam logic [1:0] STORE_SIZE   = 2'd1;
   localparam logic [1:0] STORE_STREAM = 2'd2;

   localparam int         MW      = MBITS + 1;
   localparam int         NW      = NBITS + 1;
   localparam logic [31:0] M_MAX  = M;
   localparam logic [31:0] N_MAX  = N;
   localparam logic [MBITS:0] ROW_ONE = {{MBITS{1'b0}}, 1'b1};
   localparam logic [NBITS:0] COL_ONE = {{NBITS{1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]                 state_q, state_d;
   logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
   logic                       err_q, err_d;
   logic [MBITS:0]             m_q, m_d;         // matrix rows as stored
   logic [NBITS:0]             n_q, n_d;         // matrix columns as stored
   logic [MBITS:0]             msz_q, msz_d;     // reported sizes (may be swapped)
   logic [NBITS:0]             nsz_q, nsz_d;
   logic [MBITS:0]             row_q, row_d;     // next element to read
   logic [NBITS:0]             col_q, col_d;
   logic                       issued_all_q, issued_all_d;
   logic                       infl_q, infl_d;   // read issued last cycle
   logic                       infl_last_q, infl_last_d;
   logic [FP-1:0]              ebuf_q [2];
   logic [FP-1:0]              ebuf_d [2];
   logic                       elast_q [2];
   logic                       elast_d [2];
   logic                       wr_q, wr_d;
   logic                       rd_q, rd_d;
   logic [1:0]                 cnt_q, cnt_d;

   logic                       accept_w;
   logic                       valid_w;
   logic                       xfer_w;
   logic [2:0]                 occ_w;
   logic                       issue_w;
   logic                       at_last_w;
   logic                       size_bad_w;
   logic                       transpose_w;

`ifdef STORE_TRANSPOSE_EN
   logic                       transpose_q, transpose_d;
   assign transpose_w = transpose_q;
`else
   assign transpose_w = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Handshake / issue qualifiers
   // ---------------------------------------------------------------------
   assign accept_w = (state_q == STORE_IDLE) && store_en_in;
   assign valid_w  = (cnt_q != 2'd0);
   assign xfer_w   = valid_w && mem_store_ready_in;

   // Slots that will still be claimed after this cycle's transfer; a new
   // read is only allowed if its data is guaranteed a buffer entry.
   assign occ_w    = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, xfer_w};
   assign issue_w  = (state_q == STORE_STREAM) && !issued_all_q && (occ_w < 3'd2);

   // (m-1, n-1) is the final element in both traversal orders.
   assign at_last_w = (row_q == (m_q - ROW_ONE)) && (col_q == (n_q - COL_ONE));

   assign size_bad_w = (reg_m_store_size_in == '0) ||
                       (reg_n_store_size_in == '0) ||
                       ({{(31-MBITS){1'b0}}, reg_m_store_size_in} > M_MAX) ||
                       ({{(31-NBITS){1'b0}}, reg_n_store_size_in} > N_MAX);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      err_d        = err_q;
      m_d          = m_q;
      n_d          = n_q;
      msz_d        = msz_q;
      nsz_d        = nsz_q;
      row_d        = row_q;
      col_d        = col_q;
      issued_all_d = issued_all_q;
      infl_d       = issue_w;
      infl_last_d  = issue_w && at_last_w;
      ebuf_d       = ebuf_q;
      elast_d      = elast_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      cnt_d        = cnt_q + {1'b0, infl_q} - {1'b0, xfer_w};
`ifdef STORE_TRANSPOSE_EN
      transpose_d  = transpose_q;
`endif

      // Returned read data lands in the buffer in arrival order.
      if (infl_q) begin
         ebuf_d[wr_q]  = reg_store_element_in;
         elast_d[wr_q] = infl_last_q;
         wr_d          = ~wr_q;
      end
      if (xfer_w) begin
         rd_d = ~rd_q;
      end

      case (state_q)
         STORE_IDLE: begin
            if (store_en_in) begin
               addr_d  = mem_store_addr_in;
               err_d   = 1'b0;
               state_d = STORE_SIZE;
`ifdef STORE_TRANSPOSE_EN
               transpose_d = mem_store_transpose_in;
`endif
            end
         end

         STORE_SIZE: begin
            if (size_bad_w) begin
               err_d   = 1'b1;
               state_d = STORE_IDLE;
            end else begin
               m_d          = reg_m_store_size_in;
               n_d          = reg_n_store_size_in;
               row_d        = '0;
               col_d        = '0;
               issued_all_d = 1'b0;
               if (transpose_w) begin
                  msz_d = MW'(reg_n_store_size_in);
                  nsz_d = NW'(reg_m_store_size_in);
               end else begin
                  msz_d = reg_m_store_size_in;
                  nsz_d = reg_n_store_size_in;
               end
               state_d = STORE_STREAM;
            end
         end

         STORE_STREAM: begin
            if (issue_w) begin
               if (at_last_w) begin
                  issued_all_d = 1'b1;
               end
               if (transpose_w) begin
                  if (row_q == (m_q - ROW_ONE)) begin
                     row_d = '0;
                     col_d = col_q + COL_ONE;
                  end else begin
                     row_d = row_q + ROW_ONE;
                  end
               end else begin
                  if (col_q == (n_q - COL_ONE)) begin
                     col_d = '0;
                     row_d = row_q + ROW_ONE;
                  end else begin
                     col_d = col_q + COL_ONE;
                  end
               end
            end
            // Final element handed over: nothing can be in flight or
            // buffered behind it, so the stream context is simply cleared.
            if (xfer_w && elast_q[rd_q]) begin
               state_d      = STORE_IDLE;
               m_d          = '0;
               n_d          = '0;
               msz_d        = '0;
               nsz_d        = '0;
               row_d        = '0;
               col_d        = '0;
               issued_all_d = 1'b0;
            end
         end

         default: begin
            state_d = STORE_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= STORE_IDLE;
         addr_q       <= '0;
         err_q        <= 1'b0;
         m_q          <= '0;
         n_q          <= '0;
         msz_q        <= '0;
         nsz_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         issued_all_q <= 1'b0;
         infl_q       <= 1'b0;
         infl_last_q  <= 1'b0;
         ebuf_q[0]    <= '0;
         ebuf_q[1]    <= '0;
         elast_q[0]   <= 1'b0;
         elast_q[1]   <= 1'b0;
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         cnt_q        <= 2'd0;
`ifdef STORE_TRANSPOSE_EN
         transpose_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         err_q        <= err_d;
         m_q          <= m_d;
         n_q          <= n_d;
         msz_q        <= msz_d;
         nsz_q        <= nsz_d;
         row_q        <= row_d;
         col_q        <= col_d;
         issued_all_q <= issued_all_d;
         infl_q       <= infl_d;
         infl_last_q  <= infl_last_d;
         ebuf_q[0]    <= ebuf_d[0];
         ebuf_q[1]    <= ebuf_d[1];
         elast_q[0]   <= elast_d[0];
         elast_q[1]   <= elast_d[1];
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
`ifdef STORE_TRANSPOSE_EN
         transpose_q  <= transpose_d;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // The size request goes out in the acceptance cycle so the sizes are
   // available while in STORE_SIZE.
   assign mem_store_ack_out     = accept_w;
   assign reg_store_en_out      = accept_w;
   assign reg_store_addr_out    = (state_q == STORE_IDLE) ? mem_store_addr_in : addr_q;
   assign mem_store_error_out   = err_q;
   assign mem_store_valid_out   = valid_w;
   assign mem_store_element_out = ebuf_q[rd_q];
   assign mem_store_last_out    = valid_w && elast_q[rd_q];
   assign mem_m_store_size_out  = msz_q;
   assign mem_n_store_size_out  = nsz_q;
   assign reg_store_rd_out      = issue_w;
   assign reg_i_store_loc_out   = row_q;
   assign reg_j_store_loc_out   = col_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_store.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_mpu_store                                                  |
// | Purpose  : Directed self-checking bench for mpu_store with a small       |
// |            register-file responder model.                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mpu_store;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_en;
   logic [1:0]  addr;
   logic        transpose;
   logic        ack, err, valid, ready, last;
   logic [31:0] elem;
   logic [2:0]  msz, nsz;
   logic        reg_en;
   logic [1:0]  reg_addr;
   logic [2:0]  rm_q = '0;
   logic [2:0]  rn_q = '0;
   logic        rd;
   logic [2:0]  iloc, jloc;
   logic [31:0] relem_q = '0;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mpu_store dut (
      .clk                   (clk),
      .rst                   (rst),
      .store_en_in           (store_en),
      .mem_store_addr_in     (addr),
`ifdef STORE_TRANSPOSE_EN
      .mem_store_transpose_in(transpose),
`endif
      .mem_store_ack_out     (ack),
      .mem_store_error_out   (err),
      .mem_store_valid_out   (valid),
      .mem_store_ready_in    (ready),
      .mem_store_element_out (elem),
      .mem_store_last_out    (last),
      .mem_m_store_size_out  (msz),
      .mem_n_store_size_out  (nsz),
      .reg_store_en_out      (reg_en),
      .reg_store_addr_out    (reg_addr),
      .reg_m_store_size_in   (rm_q),
      .reg_n_store_size_in   (rn_q),
      .reg_store_rd_out      (rd),
      .reg_i_store_loc_out   (iloc),
      .reg_j_store_loc_out   (jloc),
      .reg_store_element_in  (relem_q)
   );

   // Element k of a matrix holds the float value k+1 (row-major index).
   logic [31:0] fv [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
   logic [2:0]  tm [4];
   logic [2:0]  tn [4];
   int          cur_n = 1;

   // Register-file responder: one-cycle read latency for sizes and data.
   always @(posedge clk) begin
      if (reg_en) begin
         rm_q  <= tm[reg_addr];
         rn_q  <= tn[reg_addr];
         cur_n <= int'(tn[reg_addr]);
      end
      if (rd) begin
         relem_q <= fv[(int'(iloc) * cur_n + int'(jloc)) % 16];
      end
   end

   // Reads issued but not yet handed to the sink, and total read strobes.
   int outst = 0, max_out = 0, rd_count = 0;
   always @(posedge clk) begin
      if (!rst) outst <= 0;
      else      outst <= outst + (rd ? 1 : 0) - ((valid && ready) ? 1 : 0);
      if (outst > max_out) max_out <= outst;
      if (rd) rd_count <= rd_count + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (compared=%0d)", compared);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset(input string p);
      chk({p, "_ack"},   ack,    0);
      chk({p, "_err"},   err,    0);
      chk({p, "_valid"}, valid,  0);
      chk({p, "_last"},  last,   0);
      chk({p, "_regen"}, reg_en, 0);
      chk({p, "_rd"},    rd,     0);
      chk({p, "_msz"},   msz,    0);
      chk({p, "_nsz"},   nsz,    0);
      chk({p, "_iloc"},  iloc,   0);
      chk({p, "_jloc"},  jloc,   0);
      chk({p, "_elem"},  elem,   0);
   endtask

   int idx;
   int base;
   int order [6] = '{0, 3, 1, 4, 2, 5};

   initial begin
      tm[0] = 3'd4; tn[0] = 3'd4;
      tm[1] = 3'd2; tn[1] = 3'd3;
      tm[2] = 3'd0; tn[2] = 3'd3;
      tm[3] = 3'd5; tn[3] = 3'd2;
      rst = 1'b0; store_en = 1'b0; addr = '0; transpose = 1'b0; ready = 1'b1;
      repeat (3) next();
      check_reset("rst0");
      rst = 1'b1;

      // ---- 2x3 at addr 1, ready high ----
      next(); store_en = 1'b1; addr = 2'd1; #1;
      chk("t1_ack", ack, 1);
      chk("t1_regen", reg_en, 1);
      chk("t1_regaddr", reg_addr, 1);
      next(); store_en = 1'b0; #1;
      chk("t1_c1_ack", ack, 0);
      chk("t1_c1_rd", rd, 0);
      next();
      chk("t1_c2_rd", rd, 1);
      chk("t1_c2_i", iloc, 0);
      chk("t1_c2_j", jloc, 0);
      chk("t1_c2_msz", msz, 2);
      chk("t1_c2_nsz", nsz, 3);
      chk("t1_c2_valid", valid, 0);
      next();
      chk("t1_c3_rd", rd, 1);
      chk("t1_c3_j", jloc, 1);
      chk("t1_c3_valid", valid, 0);
      for (int k = 0; k < 6; k++) begin
         next();
         chk($sformatf("t1_valid%0d", k), valid, 1);
         chk($sformatf("t1_elem%0d", k), elem, fv[k]);
         chk($sformatf("t1_last%0d", k), last, (k == 5));
      end
      next();
      chk("t1_end_valid", valid, 0);
      chk("t1_end_msz", msz, 0);
      chk("t1_end_nsz", nsz, 0);

      // ---- 0x3 then 5x2: dimension errors ----
      next(); store_en = 1'b1; addr = 2'd2; #1;
      chk("t2_ack", ack, 1);
      base = rd_count;
      next(); store_en = 1'b0; #1;
      next();
      chk("t2_err_c2", err, 1);
      chk("t2_valid_c2", valid, 0);
      store_en = 1'b1; addr = 2'd3; #1;
      chk("t2b_ack_idle", ack, 1);
      next(); store_en = 1'b0; #1;
      chk("t2b_err_cleared", err, 0);
      next();
      chk("t2b_err_c2", err, 1);
      next();
      chk("t2b_err_held", err, 1);
      chk("t2_no_reads", rd_count - base, 0);

      // ---- 1x1 clears the error ----
      tm[2] = 3'd1; tn[2] = 3'd1;
      store_en = 1'b1; addr = 2'd2; #1;
      chk("t3_ack", ack, 1);
      base = rd_count;
      next(); store_en = 1'b0; #1;
      chk("t3_err_clear", err, 0);
      next(); next();
      next();
      chk("t3_valid", valid, 1);
      chk("t3_elem", elem, fv[0]);
      chk("t3_last", last, 1);
      next();
      chk("t3_done", valid, 0);
      chk("t3_reads", rd_count - base, 1);

      // ---- 2x3 with ready pattern 1,0,0,1 ----
      next(); store_en = 1'b1; addr = 2'd1; ready = 1'b1; #1;
      chk("t4_ack", ack, 1);
      idx = 0;
      for (int c = 1; c < 40 && idx < 6; c++) begin
         next(); store_en = 1'b0; ready = ((c % 4) == 0) || ((c % 4) == 3); #1;
         if (valid) begin
            chk($sformatf("t4_elem_c%0d", c), elem, fv[idx]);
            chk($sformatf("t4_last_c%0d", c), last, (idx == 5));
            if (ready) idx++;
         end
      end
      chk("t4_count", idx, 6);
      next(); ready = 1'b1; #1;
      chk("t4_end_valid", valid, 0);
      chk("t4_capacity", (max_out <= 2), 1);

      // ---- 4x4 aborted by reset on 3rd element ----
      next(); store_en = 1'b1; addr = 2'd0; #1;
      chk("t5_ack", ack, 1);
      next(); store_en = 1'b0; #1;
      repeat (4) next();
      next();
      chk("t5_third_valid", valid, 1);
      chk("t5_third_elem", elem, fv[2]);
      rst = 1'b0;
      next();
      check_reset("t5_rst");
      rst = 1'b1;
      base = rd_count;
      next();
      chk("t5_no_rd", rd, 0);
      chk("t5_no_reads", rd_count - base, 0);

      // ---- full 4x4, store_en pulsed mid-stream ----
      store_en = 1'b1; addr = 2'd0; #1;
      chk("t6_ack", ack, 1);
      base = rd_count;
      next(); store_en = 1'b0; #1;
      next();
      chk("t6_msz", msz, 4);
      chk("t6_nsz", nsz, 4);
      next();
      for (int k = 0; k < 16; k++) begin
         next();
         if (k == 1) begin
            store_en = 1'b1; addr = 2'd1; #1;
            chk("t6_ack_ignored", ack, 0);
            chk("t6_regen_ignored", reg_en, 0);
         end
         chk($sformatf("t6_valid%0d", k), valid, 1);
         chk($sformatf("t6_elem%0d", k), elem, fv[k]);
         chk($sformatf("t6_last%0d", k), last, (k == 15));
         store_en = 1'b0;
      end
      next();
      chk("t6_end_valid", valid, 0);
      chk("t6_reads", rd_count - base, 16);

`ifdef STORE_TRANSPOSE_EN
      // ---- 2x3 transposed ----
      next(); store_en = 1'b1; addr = 2'd1; transpose = 1'b1; #1;
      chk("t7_ack", ack, 1);
      next(); store_en = 1'b0; transpose = 1'b0; #1;
      next();
      chk("t7_msz", msz, 3);
      chk("t7_nsz", nsz, 2);
      next();
      for (int k = 0; k < 6; k++) begin
         next();
         chk($sformatf("t7_elem%0d", k), elem, fv[order[k]]);
         chk($sformatf("t7_last%0d", k), last, (k == 5));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
